// File: rtl/cpu_pkg.sv
// Shared RV32I memory-stage definitions: funct3 width codes and the LSU state encoding.
package cpu_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and extends it; flags misaligned or illegal loads.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        fault
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = word[{offset, 3'b000} +: 8];
    assign lane_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data  = 32'h0;
        fault = 1'b0;
        case (funct3)
            LB:  data = {{24{lane_byte[7]}}, lane_byte};
            LBU: data = {24'h0, lane_byte};
            LH:  begin fault = offset[0];        data = {{16{lane_half[15]}}, lane_half}; end
            LHU: begin fault = offset[0];        data = {16'h0, lane_half}; end
            LW:  begin fault = (offset != 2'b00); data = word; end
            default: fault = 1'b1;
        endcase
        // A faulting load returns zero regardless of what the lane held.
        if (fault) data = 32'h0;
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: fixed-latency access to a private word-addressed data memory with byte-lane stores.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            store_data,
    input  logic [DEPTH-1:0][31:0] initial_memory,
    output logic                   ready,
    output logic                   stall,
    output logic                   done,
    output logic [31:0]            load_data,
    output logic                   misaligned,
    output logic [DEPTH-1:0][31:0] memory_check
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    lsu_state_t             state, state_next;
    logic [CW-1:0]          cnt;
    logic                   store_q;
    logic [2:0]             funct3_q;
    logic [31:0]            addr_q;
    logic [31:0]            data_q;
    logic [DEPTH-1:0][31:0] mem;

    logic [AW-1:0] idx;
    logic          complete;
    logic [31:0]   ld_data;
    logic          ld_fault;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic          st_fault;

    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign idx      = addr_q[AW+1:2];
    assign complete = (state == BUSY) && (cnt == CW'(1));

    load_align u_align (
        .word   (mem[idx]),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (ld_data),
        .fault  (ld_fault)
    );

    always_comb begin
        byte_en  = 4'b0000;
        wr_data  = data_q;
        st_fault = 1'b0;
        case (funct3_q)
            SB: begin byte_en = 4'b0001 << addr_q[1:0]; wr_data = {4{data_q[7:0]}}; end
            SH: begin
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{data_q[15:0]}};
                st_fault = addr_q[0];
            end
            SW: begin byte_en = 4'b1111; st_fault = (addr_q[1:0] != 2'b00); end
            default: st_fault = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = BUSY;
            BUSY:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
            mem        <= initial_memory;
        end else begin
            state <= state_next;
            if (state == IDLE && valid) begin
                store_q  <= is_store;
                funct3_q <= funct3;
                addr_q   <= addr;
                data_q   <= store_data;
                cnt      <= CW'(LATENCY);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
            end
            if (complete) begin
                if (store_q) begin
                    load_data  <= 32'h0;
                    misaligned <= st_fault;
                    if (!st_fault)
                        for (int b = 0; b < 4; b++)
                            if (byte_en[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end else begin
                    load_data  <= ld_data;
                    misaligned <= ld_fault;
                end
            end
        end
    end

    assign ready        = (state == IDLE);
    assign done         = (state == DONE);
    assign stall        = ((state == IDLE) && valid) || (state == BUSY);
    assign memory_check = mem;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard queue of expected completions checked by a done monitor.
module tb_load_store_unit;
    import cpu_pkg::*;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   valid;
    logic                   is_store;
    logic [2:0]             funct3;
    logic [31:0]            addr;
    logic [31:0]            store_data;
    logic [DEPTH-1:0][31:0] initial_memory;
    logic                   ready, stall, done, misaligned;
    logic [31:0]            load_data;
    logic [DEPTH-1:0][31:0] memory_check;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    load_store_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .initial_memory (initial_memory),
        .ready          (ready),
        .stall          (stall),
        .done           (done),
        .load_data      (load_data),
        .misaligned     (misaligned),
        .memory_check   (memory_check)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                check32("load_data", load_data, e.data);
                check32("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
            end
        end
    end

    // Issue one access, hold valid until done; reports negedges waited and cycles stalled.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] ed, input logic em,
                          output int waits, output int stalls);
        exp_t e;
        @(negedge clk);
        valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        e.data = ed; e.mis = em;
        exp_q.push_back(e);
        #1;
        stalls = stall ? 1 : 0;
        waits  = 0;
        while (waits < 20) begin
            @(negedge clk);
            waits++;
            if (done) break;
            if (stall) stalls++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
        valid = 1'b0;
    endtask

    initial begin
        int w, s, gap;
        for (int i = 0; i < DEPTH; i++) initial_memory[i] = 32'h1000_0000 + i;
        initial_memory[1] = 32'h8081_7F01;
        valid = 0; is_store = 0; funct3 = 3'b000; addr = 0; store_data = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("reset_ready", {31'h0, ready}, 32'h1);
        check32("reset_done", {31'h0, done}, 32'h0);
        check32("reset_load_data", load_data, 32'h0);
        check32("reset_misaligned", {31'h0, misaligned}, 32'h0);
        check32("reset_mem5", memory_check[5], 32'h1000_0005);

        access(0, LW, 32'd4, 0, 32'h8081_7F01, 0, w, s);
        check32("lw_latency", w, 3);
        check32("lw_stall_cycles", s, 3);

        access(0, LB,  32'd7, 0, 32'hFFFF_FF80, 0, w, s);
        access(0, LBU, 32'd7, 0, 32'h0000_0080, 0, w, s);
        access(0, LB,  32'd5, 0, 32'h0000_007F, 0, w, s);
        access(0, LHU, 32'd6, 0, 32'h0000_8081, 0, w, s);
        access(0, LH,  32'd6, 0, 32'hFFFF_8081, 0, w, s);
        access(0, LW,  32'h84, 0, 32'h8081_7F01, 0, w, s);

        access(1, SB, 32'd9, 32'h0000_00AA, 32'h0, 0, w, s);
        check32("sb_mem2", memory_check[2], 32'h1000_AA02);
        access(1, SH, 32'd10, 32'h0000_1234, 32'h0, 0, w, s);
        check32("sh_mem2", memory_check[2], 32'h1234_AA02);
        access(0, LW, 32'd8, 0, 32'h1234_AA02, 0, w, s);

        access(0, LW, 32'd6, 0, 32'h0, 1, w, s);
        access(0, 3'b011, 32'd0, 0, 32'h0, 1, w, s);
        access(1, SW, 32'd5, 32'hFFFF_FFFF, 32'h0, 1, w, s);
        check32("sw_fault_mem1", memory_check[1], 32'h8081_7F01);

        // valid held high across DONE: one pulse, then re-accept on the edge after DONE.
        @(negedge clk);
        valid = 1'b1; is_store = 0; funct3 = LW; addr = 32'd12;
        exp_q.push_back('{data: 32'h1000_0003, mis: 1'b0});
        exp_q.push_back('{data: 32'h1000_0003, mis: 1'b0});
        w = 0;
        while (!done && w < 20) begin @(negedge clk); w++; end
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 20);
        valid = 1'b0;
        check32("held_valid_gap", gap, LATENCY + 2);
        @(negedge clk);
        check32("held_valid_single", {31'h0, done}, 32'h0);

        // Reset mid-BUSY aborts the store.
        @(negedge clk);
        valid = 1'b1; is_store = 1; funct3 = SW; addr = 32'd0; store_data = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        check32("abort_ready", {31'h0, ready}, 32'h1);
        repeat (LATENCY + 2) @(negedge clk);
        check32("abort_mem0", memory_check[0], 32'h1000_0000);

        check32("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
